mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/mem_bus_arbiter_slice.sv | 54 +++++
 rtl/mem_bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the memory bus arbiter slice: the default bus
//   width, the read FSM state encoding and the read-owner encoding.
//   Ports: none (package only).
package mem_bus_arbiter_pkg;

  localparam int ARB_BUS_WIDTH   = 32;
  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } arb_owner_t;

  // The last-grant register starts on the port that should LOSE the first tie.
  function automatic arb_owner_t reset_last_grant(input bit d_first);
    return d_first ? ARB_OWNER_I : ARB_OWNER_D;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_slice.sv
// bus_reg_slice
//   One-entry valid/ready register. An entry is accepted only while the
//   register is empty and is released by the downstream handshake.
//   Ports:
//     clk, rst              clock, synchronous active-low reset
//     in_valid/in_ready     upstream handshake, in_data payload
//     out_valid/out_ready   downstream handshake, out_data payload
module bus_reg_slice
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = ARB_BUS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !full_q;
  assign out_valid = full_q;
  assign out_data  = data_q;

  // Accept and release can never coincide: accept needs the entry empty,
  // release needs it full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (out_valid && out_ready) begin
      full_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates an instruction read port and a data read/write port onto a
//   single memory bus. Reads: round-robin grant, one outstanding read,
//   IDLE -> REQ -> RESP. Writes: address and data each buffered in a
//   one-entry slice and issued to memory together once both are present.
//   Data reads are held off while any write is buffered or in flight.
//   Ports:
//     clk, rst                       clock, synchronous active-low reset
//     i_raddr_*, i_rdata_*           instruction read channels
//     i_waddr_ready, i_wdata_ready   always 0 (instruction port is read-only)
//     d_raddr_*, d_rdata_*           data read channels
//     d_waddr_*, d_wdata_*           data write channels
//     m_*                            memory-side channels
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH = ARB_BUS_WIDTH,
  parameter int D_FIRST   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // instruction port
  input  logic                 i_raddr_valid,
  input  logic [BUS_WIDTH-1:0] i_raddr,
  output logic                 i_raddr_ready,
  output logic                 i_rdata_valid,
  output logic [BUS_WIDTH-1:0] i_rdata,
  input  logic                 i_rdata_ready,
  output logic                 i_waddr_ready,
  output logic                 i_wdata_ready,
  // data port
  input  logic                 d_raddr_valid,
  input  logic [BUS_WIDTH-1:0] d_raddr,
  output logic                 d_raddr_ready,
  output logic                 d_rdata_valid,
  output logic [BUS_WIDTH-1:0] d_rdata,
  input  logic                 d_rdata_ready,
  input  logic                 d_waddr_valid,
  input  logic [BUS_WIDTH-1:0] d_waddr,
  output logic                 d_waddr_ready,
  input  logic                 d_wdata_valid,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  output logic                 d_wdata_ready,
  // memory port
  output logic                 m_raddr_valid,
  output logic [BUS_WIDTH-1:0] m_raddr,
  input  logic                 m_raddr_ready,
  input  logic                 m_rdata_valid,
  input  logic [BUS_WIDTH-1:0] m_rdata,
  output logic                 m_rdata_ready,
  output logic                 m_waddr_valid,
  output logic [BUS_WIDTH-1:0] m_waddr,
  input  logic                 m_waddr_ready,
  output logic                 m_wdata_valid,
  output logic [BUS_WIDTH-1:0] m_wdata,
  input  logic                 m_wdata_ready
);

  arb_state_t           state_q, state_d;
  arb_owner_t           owner_q, owner_d;
  arb_owner_t           last_grant_q, last_grant_d;
  logic [BUS_WIDTH-1:0] m_raddr_q, m_raddr_d;
  logic                 m_raddr_valid_q, m_raddr_valid_d;
  logic                 drain_q, drain_d;

  logic waddr_in_valid, waddr_in_ready, waddr_full, waddr_out_ready;
  logic wdata_in_valid, wdata_in_ready, wdata_full, wdata_out_ready;
  logic write_present, write_busy, waddr_xfer, wdata_xfer, writes_empty_next;
  logic i_elig, d_elig, grant_i, grant_d, in_idle, in_resp;

  assign i_waddr_ready = 1'b0;
  assign i_wdata_ready = 1'b0;

  // ---------------------------------------------------------------- writes
  // drain_q marks a write pair that has been presented to memory but not yet
  // fully accepted; it keeps the surviving half valid after its partner has
  // left and keeps both entries closed until the pair is gone.
  assign write_present  = (waddr_full && wdata_full) || drain_q;
  assign write_busy     = waddr_full || wdata_full || drain_q;

  assign waddr_in_valid = d_waddr_valid && !drain_q;
  assign wdata_in_valid = d_wdata_valid && !drain_q;
  assign d_waddr_ready  = waddr_in_ready && !drain_q;
  assign d_wdata_ready  = wdata_in_ready && !drain_q;

  assign m_waddr_valid   = rst && waddr_full && write_present;
  assign m_wdata_valid   = rst && wdata_full && write_present;
  assign waddr_out_ready = m_waddr_ready && m_waddr_valid;
  assign wdata_out_ready = m_wdata_ready && m_wdata_valid;
  assign waddr_xfer      = waddr_out_ready;
  assign wdata_xfer      = wdata_out_ready;

  assign writes_empty_next = (!waddr_full || waddr_xfer) && (!wdata_full || wdata_xfer);
  assign drain_d           = write_present && !writes_empty_next;

  bus_reg_slice #(.WIDTH(BUS_WIDTH)) u_waddr_slice (
    .clk      (clk),
    .rst      (rst),
    .in_valid (waddr_in_valid),
    .in_data  (d_waddr),
    .in_ready (waddr_in_ready),
    .out_valid(waddr_full),
    .out_data (m_waddr),
    .out_ready(waddr_out_ready)
  );

  bus_reg_slice #(.WIDTH(BUS_WIDTH)) u_wdata_slice (
    .clk      (clk),
    .rst      (rst),
    .in_valid (wdata_in_valid),
    .in_data  (d_wdata),
    .in_ready (wdata_in_ready),
    .out_valid(wdata_full),
    .out_data (m_wdata),
    .out_ready(wdata_out_ready)
  );

  // ----------------------------------------------------------------- reads
  // Outputs are gated with rst so nothing handshakes while reset is held,
  // regardless of the state left over from before the reset edge.
  assign in_idle = rst && (state_q == ARB_IDLE);
  assign in_resp = rst && (state_q == ARB_RESP);

  assign i_elig  = i_raddr_valid;
  assign d_elig  = d_raddr_valid && !write_busy;
  assign grant_d = d_elig && (!i_elig || (last_grant_q == ARB_OWNER_I));
  assign grant_i = i_elig && !grant_d;

  assign i_raddr_ready = in_idle && grant_i;
  assign d_raddr_ready = in_idle && grant_d;

  assign m_raddr_valid = rst && m_raddr_valid_q;
  assign m_raddr       = m_raddr_q;

  assign i_rdata_valid = in_resp && (owner_q == ARB_OWNER_I) && m_rdata_valid;
  assign d_rdata_valid = in_resp && (owner_q == ARB_OWNER_D) && m_rdata_valid;
  assign i_rdata       = m_rdata;
  assign d_rdata       = m_rdata;
  assign m_rdata_ready = in_resp && ((owner_q == ARB_OWNER_I) ? i_rdata_ready : d_rdata_ready);

  // Next-state logic for the read FSM; m_raddr_valid is registered so it is
  // high exactly while the FSM sits in REQ.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    m_raddr_d       = m_raddr_q;
    m_raddr_valid_d = m_raddr_valid_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d         = ARB_REQ;
          owner_d         = ARB_OWNER_D;
          last_grant_d    = ARB_OWNER_D;
          m_raddr_d       = d_raddr;
          m_raddr_valid_d = 1'b1;
        end else if (grant_i) begin
          state_d         = ARB_REQ;
          owner_d         = ARB_OWNER_I;
          last_grant_d    = ARB_OWNER_I;
          m_raddr_d       = i_raddr;
          m_raddr_valid_d = 1'b1;
        end
      end
      ARB_REQ: begin
        if (m_raddr_ready) begin
          state_d         = ARB_RESP;
          m_raddr_valid_d = 1'b0;
        end
      end
      ARB_RESP: begin
        if (m_rdata_valid && m_rdata_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d         = ARB_IDLE;
        m_raddr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ARB_IDLE;
      owner_q         <= ARB_OWNER_I;
      last_grant_q    <= reset_last_grant(D_FIRST != 0);
      m_raddr_q       <= '0;
      m_raddr_valid_q <= 1'b0;
      drain_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      m_raddr_q       <= m_raddr_d;
      m_raddr_valid_q <= m_raddr_valid_d;
      drain_q         <= drain_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter: reset values, a table of grant
//   vectors, hand-written write / stall / reset sequences and a randomized
//   run compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
  logic [31:0] i_raddr, i_rdata;
  logic        i_waddr_ready, i_wdata_ready;
  logic        d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
  logic [31:0] d_raddr, d_rdata;
  logic        d_waddr_valid, d_waddr_ready, d_wdata_valid, d_wdata_ready;
  logic [31:0] d_waddr, d_wdata;
  logic        m_raddr_valid, m_raddr_ready, m_rdata_valid, m_rdata_ready;
  logic [31:0] m_raddr, m_rdata;
  logic        m_waddr_valid, m_waddr_ready, m_wdata_valid, m_wdata_ready;
  logic [31:0] m_waddr, m_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_arbiter #(.BUS_WIDTH(32), .D_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_valid(i_raddr_valid), .i_raddr(i_raddr), .i_raddr_ready(i_raddr_ready),
    .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata), .i_rdata_ready(i_rdata_ready),
    .i_waddr_ready(i_waddr_ready), .i_wdata_ready(i_wdata_ready),
    .d_raddr_valid(d_raddr_valid), .d_raddr(d_raddr), .d_raddr_ready(d_raddr_ready),
    .d_rdata_valid(d_rdata_valid), .d_rdata(d_rdata), .d_rdata_ready(d_rdata_ready),
    .d_waddr_valid(d_waddr_valid), .d_waddr(d_waddr), .d_waddr_ready(d_waddr_ready),
    .d_wdata_valid(d_wdata_valid), .d_wdata(d_wdata), .d_wdata_ready(d_wdata_ready),
    .m_raddr_valid(m_raddr_valid), .m_raddr(m_raddr), .m_raddr_ready(m_raddr_ready),
    .m_rdata_valid(m_rdata_valid), .m_rdata(m_rdata), .m_rdata_ready(m_rdata_ready),
    .m_waddr_valid(m_waddr_valid), .m_waddr(m_waddr), .m_waddr_ready(m_waddr_ready),
    .m_wdata_valid(m_wdata_valid), .m_wdata(m_wdata), .m_wdata_ready(m_wdata_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit i_req;
    bit d_req;
    bit exp_i;
    bit exp_d;
  } grant_vec_t;

  grant_vec_t vecs[9];

  // reference model state: one outstanding read, write entry queues
  bit          md_rd_busy;
  bit          md_rd_sent;
  bit          md_rd_is_d;
  logic [31:0] md_rd_addr;
  bit          md_last_d;
  logic [31:0] md_wa_q[$];
  logic [31:0] md_wd_q[$];
  bit          md_wr_locked;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_raddr_valid = 1'b0; i_raddr = '0; i_rdata_ready = 1'b0;
    d_raddr_valid = 1'b0; d_raddr = '0; d_rdata_ready = 1'b0;
    d_waddr_valid = 1'b0; d_waddr = '0; d_wdata_valid = 1'b0; d_wdata = '0;
    m_raddr_ready = 1'b0; m_rdata_valid = 1'b0; m_rdata = '0;
    m_waddr_ready = 1'b0; m_wdata_ready = 1'b0;
  endtask

  // One table row: request pattern in IDLE, then the full read it produces.
  task automatic apply_stimulus(input grant_vec_t v, input int k);
    logic [31:0] ia, da, rd;
    ia = 32'h1000 + 32'(k) * 16;
    da = 32'h2000 + 32'(k) * 16;
    rd = 32'hA000_0000 + 32'(k);
    i_raddr_valid = v.i_req; i_raddr = ia;
    d_raddr_valid = v.d_req; d_raddr = da;
    m_raddr_ready = 1'b1; m_rdata_valid = 1'b1; m_rdata = rd;
    i_rdata_ready = 1'b1; d_rdata_ready = 1'b1;
    settle();
    check_output($sformatf("vec%0d i_raddr_ready", k), i_raddr_ready, v.exp_i);
    check_output($sformatf("vec%0d d_raddr_ready", k), d_raddr_ready, v.exp_d);
    advance();
    if (v.exp_i || v.exp_d) begin
      settle();
      check_output($sformatf("vec%0d req m_raddr_valid", k), m_raddr_valid, 1'b1);
      check_output($sformatf("vec%0d req m_raddr", k), m_raddr, v.exp_d ? da : ia);
      check_output($sformatf("vec%0d req i_raddr_ready", k), i_raddr_ready, 1'b0);
      check_output($sformatf("vec%0d req d_raddr_ready", k), d_raddr_ready, 1'b0);
      check_output($sformatf("vec%0d req i_rdata_valid", k), i_rdata_valid, 1'b0);
      advance();
      settle();
      check_output($sformatf("vec%0d resp i_rdata_valid", k), i_rdata_valid, v.exp_i);
      check_output($sformatf("vec%0d resp d_rdata_valid", k), d_rdata_valid, v.exp_d);
      check_output($sformatf("vec%0d resp rdata", k), v.exp_d ? d_rdata : i_rdata, rd);
      check_output($sformatf("vec%0d resp m_rdata_ready", k), m_rdata_ready, 1'b1);
      check_output($sformatf("vec%0d resp i_raddr_ready", k), i_raddr_ready, 1'b0);
      advance();
    end
  endtask

  // One random cycle: predict every output from the model, compare, then
  // retire whatever handshakes the model says happened.
  task automatic model_step();
    bit batch, pend, cand_i, cand_d, win_i, win_d;
    bit e_wa_rdy, e_wd_rdy, e_mwa_v, e_mwd_v, e_mra_v, dphase;
    bit e_ir_v, e_dr_v, e_mrd_rdy;
    settle();
    batch    = (md_wa_q.size() == 1 && md_wd_q.size() == 1) || md_wr_locked;
    e_wa_rdy = (md_wa_q.size() == 0) && !md_wr_locked;
    e_wd_rdy = (md_wd_q.size() == 0) && !md_wr_locked;
    e_mwa_v  = (md_wa_q.size() == 1) && batch;
    e_mwd_v  = (md_wd_q.size() == 1) && batch;
    pend     = (md_wa_q.size() + md_wd_q.size() > 0) || md_wr_locked;
    cand_i   = !md_rd_busy && i_raddr_valid;
    cand_d   = !md_rd_busy && d_raddr_valid && !pend;
    win_d    = cand_d && (!cand_i || !md_last_d);
    win_i    = cand_i && !win_d;
    e_mra_v  = md_rd_busy && !md_rd_sent;
    dphase   = md_rd_busy && md_rd_sent;
    e_ir_v   = dphase && !md_rd_is_d && m_rdata_valid;
    e_dr_v   = dphase && md_rd_is_d && m_rdata_valid;
    e_mrd_rdy = dphase && (md_rd_is_d ? d_rdata_ready : i_rdata_ready);

    check_output("rand i_raddr_ready", i_raddr_ready, win_i);
    check_output("rand d_raddr_ready", d_raddr_ready, win_d);
    check_output("rand m_raddr_valid", m_raddr_valid, e_mra_v);
    check_output("rand i_rdata_valid", i_rdata_valid, e_ir_v);
    check_output("rand d_rdata_valid", d_rdata_valid, e_dr_v);
    check_output("rand m_rdata_ready", m_rdata_ready, e_mrd_rdy);
    check_output("rand d_waddr_ready", d_waddr_ready, e_wa_rdy);
    check_output("rand d_wdata_ready", d_wdata_ready, e_wd_rdy);
    check_output("rand m_waddr_valid", m_waddr_valid, e_mwa_v);
    check_output("rand m_wdata_valid", m_wdata_valid, e_mwd_v);
    if (e_mra_v) check_output("rand m_raddr", m_raddr, md_rd_addr);
    if (e_ir_v)  check_output("rand i_rdata", i_rdata, m_rdata);
    if (e_dr_v)  check_output("rand d_rdata", d_rdata, m_rdata);
    if (e_mwa_v) check_output("rand m_waddr", m_waddr, md_wa_q[0]);
    if (e_mwd_v) check_output("rand m_wdata", m_wdata, md_wd_q[0]);

    if (win_i || win_d) begin
      md_rd_busy = 1'b1;
      md_rd_sent = 1'b0;
      md_rd_is_d = win_d;
      md_rd_addr = win_d ? d_raddr : i_raddr;
      md_last_d  = win_d;
    end else if (e_mra_v && m_raddr_ready) begin
      md_rd_sent = 1'b1;
    end else if (dphase && m_rdata_valid && e_mrd_rdy) begin
      md_rd_busy = 1'b0;
    end
    if (e_mwa_v && m_waddr_ready) void'(md_wa_q.pop_front());
    if (e_mwd_v && m_wdata_ready) void'(md_wd_q.pop_front());
    md_wr_locked = batch && !(md_wa_q.size() == 0 && md_wd_q.size() == 0);
    if (e_wa_rdy && d_waddr_valid) md_wa_q.push_back(d_waddr);
    if (e_wd_rdy && d_wdata_valid) md_wd_q.push_back(d_wdata);
    advance();
  endtask

  initial begin
    // request pattern -> expected grant, starting from reset with D_FIRST=1
    vecs[0] = '{1, 1, 0, 1};
    vecs[1] = '{1, 1, 1, 0};
    vecs[2] = '{1, 1, 0, 1};
    vecs[3] = '{1, 1, 1, 0};
    vecs[4] = '{1, 0, 1, 0};
    vecs[5] = '{1, 1, 0, 1};
    vecs[6] = '{0, 1, 0, 1};
    vecs[7] = '{0, 0, 0, 0};
    vecs[8] = '{1, 1, 1, 0};

    // ---- reset: requests and memory data offered, nothing may handshake
    idle_inputs();
    rst = 1'b0;
    i_raddr_valid = 1'b1; d_raddr_valid = 1'b1; m_rdata_valid = 1'b1;
    i_rdata_ready = 1'b1; d_rdata_ready = 1'b1;
    advance();
    advance();
    settle();
    check_output("reset i_raddr_ready", i_raddr_ready, 1'b0);
    check_output("reset d_raddr_ready", d_raddr_ready, 1'b0);
    check_output("reset m_raddr_valid", m_raddr_valid, 1'b0);
    check_output("reset m_rdata_ready", m_rdata_ready, 1'b0);
    check_output("reset i_rdata_valid", i_rdata_valid, 1'b0);
    check_output("reset d_rdata_valid", d_rdata_valid, 1'b0);
    check_output("reset m_waddr_valid", m_waddr_valid, 1'b0);
    check_output("reset m_wdata_valid", m_wdata_valid, 1'b0);
    check_output("reset d_waddr_ready", d_waddr_ready, 1'b1);
    check_output("reset d_wdata_ready", d_wdata_ready, 1'b1);
    check_output("reset i_waddr_ready", i_waddr_ready, 1'b0);
    check_output("reset i_wdata_ready", i_wdata_ready, 1'b0);
    advance();
    idle_inputs();
    rst = 1'b1;

    // ---- table of grant vectors (round-robin, sole requester, none)
    for (int k = 0; k < 9; k++) apply_stimulus(vecs[k], k);
    idle_inputs();

    // ---- single instruction read at 0x100 with an always-ready memory
    i_raddr_valid = 1'b1; i_raddr = 32'h100; i_rdata_ready = 1'b1;
    m_raddr_ready = 1'b1; m_rdata_valid = 1'b1; m_rdata = 32'hDEADBEEF;
    settle();
    check_output("ionly grant", i_raddr_ready, 1'b1);
    advance();
    settle();
    check_output("ionly req m_raddr", m_raddr, 32'h100);
    check_output("ionly req i_raddr_ready", i_raddr_ready, 1'b0);
    check_output("ionly req i_rdata_valid", i_rdata_valid, 1'b0);
    advance();
    settle();
    check_output("ionly resp i_rdata_valid", i_rdata_valid, 1'b1);
    check_output("ionly resp i_rdata", i_rdata, 32'hDEADBEEF);
    check_output("ionly resp d_rdata_valid", d_rdata_valid, 1'b0);
    check_output("ionly resp i_raddr_ready", i_raddr_ready, 1'b0);
    i_raddr_valid = 1'b0;
    advance();
    idle_inputs();

    // ---- write 0x40/0x55 three cycles apart, then a blocked read of 0x40
    d_waddr_valid = 1'b1; d_waddr = 32'h40;
    settle();
    check_output("wr waddr accept", d_waddr_ready, 1'b1);
    advance();
    d_waddr_valid = 1'b0;
    d_raddr_valid = 1'b1; d_raddr = 32'h40;
    for (int c = 0; c < 2; c++) begin
      settle();
      check_output("wr half m_waddr_valid", m_waddr_valid, 1'b0);
      check_output("wr half d_raddr_ready", d_raddr_ready, 1'b0);
      check_output("wr half d_waddr_ready", d_waddr_ready, 1'b0);
      advance();
    end
    d_wdata_valid = 1'b1; d_wdata = 32'h55;
    settle();
    check_output("wr wdata accept", d_wdata_ready, 1'b1);
    check_output("wr pre m_wdata_valid", m_wdata_valid, 1'b0);
    advance();
    d_wdata_valid = 1'b0;
    settle();
    check_output("wr both m_waddr_valid", m_waddr_valid, 1'b1);
    check_output("wr both m_wdata_valid", m_wdata_valid, 1'b1);
    check_output("wr both m_waddr", m_waddr, 32'h40);
    check_output("wr both m_wdata", m_wdata, 32'h55);
    check_output("wr both d_raddr_ready", d_raddr_ready, 1'b0);
    advance();
    m_waddr_ready = 1'b1;
    settle();
    check_output("wr addr xfer m_wdata_valid", m_wdata_valid, 1'b1);
    advance();
    m_waddr_ready = 1'b0;
    settle();
    check_output("wr drain m_waddr_valid", m_waddr_valid, 1'b0);
    check_output("wr drain m_wdata_valid", m_wdata_valid, 1'b1);
    check_output("wr drain d_waddr_ready", d_waddr_ready, 1'b0);
    check_output("wr drain d_raddr_ready", d_raddr_ready, 1'b0);
    advance();
    m_wdata_ready = 1'b1;
    settle();
    check_output("wr last d_raddr_ready", d_raddr_ready, 1'b0);
    advance();
    m_wdata_ready = 1'b0;
    m_raddr_ready = 1'b1; m_rdata_valid = 1'b1; m_rdata = 32'h0000_0055; d_rdata_ready = 1'b1;
    settle();
    check_output("wr done d_raddr_ready", d_raddr_ready, 1'b1);
    check_output("wr done d_waddr_ready", d_waddr_ready, 1'b1);
    check_output("wr done m_wdata_valid", m_wdata_valid, 1'b0);
    advance();
    d_raddr_valid = 1'b0;
    settle();
    check_output("wr rd m_raddr", m_raddr, 32'h40);
    advance();
    settle();
    check_output("wr rd d_rdata_valid", d_rdata_valid, 1'b1);
    advance();
    idle_inputs();

    // ---- address stall 5 cycles, then data back-pressure 2 cycles
    i_raddr_valid = 1'b1; i_raddr = 32'h300;
    settle();
    check_output("stall grant", i_raddr_ready, 1'b1);
    advance();
    i_raddr_valid = 1'b0;
    d_raddr_valid = 1'b1; d_raddr = 32'h500;
    for (int c = 0; c < 5; c++) begin
      settle();
      check_output("stall m_raddr_valid", m_raddr_valid, 1'b1);
      check_output("stall m_raddr", m_raddr, 32'h300);
      check_output("stall d_raddr_ready", d_raddr_ready, 1'b0);
      advance();
    end
    m_raddr_ready = 1'b1;
    advance();
    m_raddr_ready = 1'b0;
    m_rdata_valid = 1'b1; m_rdata = 32'h1234_5678; i_rdata_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      check_output("bp m_rdata_ready", m_rdata_ready, 1'b0);
      check_output("bp i_rdata_valid", i_rdata_valid, 1'b1);
      check_output("bp i_rdata", i_rdata, 32'h1234_5678);
      check_output("bp d_rdata_valid", d_rdata_valid, 1'b0);
      check_output("bp d_raddr_ready", d_raddr_ready, 1'b0);
      advance();
    end
    i_rdata_ready = 1'b1;
    d_raddr_valid = 1'b0;
    settle();
    check_output("bp release m_rdata_ready", m_rdata_ready, 1'b1);
    advance();
    idle_inputs();

    // ---- reset while in RESP with memory data pending
    i_raddr_valid = 1'b1; i_raddr = 32'h700; m_raddr_ready = 1'b1;
    advance();
    i_raddr_valid = 1'b0;
    advance();
    m_raddr_ready = 1'b0;
    m_rdata_valid = 1'b1; m_rdata = 32'hBAD0_BAD0; i_rdata_ready = 1'b1;
    rst = 1'b0;
    settle();
    check_output("rstresp m_rdata_ready", m_rdata_ready, 1'b0);
    check_output("rstresp i_rdata_valid", i_rdata_valid, 1'b0);
    advance();
    rst = 1'b1;
    i_raddr_valid = 1'b1; i_raddr = 32'h800; m_raddr_ready = 1'b1;
    settle();
    check_output("post i_rdata_valid", i_rdata_valid, 1'b0);
    check_output("post d_rdata_valid", d_rdata_valid, 1'b0);
    check_output("post m_rdata_ready", m_rdata_ready, 1'b0);
    check_output("post m_raddr_valid", m_raddr_valid, 1'b0);
    check_output("post i_raddr_ready", i_raddr_ready, 1'b1);
    advance();
    i_raddr_valid = 1'b0;
    settle();
    check_output("post m_raddr", m_raddr, 32'h800);
    advance();
    m_rdata = 32'h0000_0800;
    settle();
    check_output("post i_rdata", i_rdata_valid ? i_rdata : 32'h0, 32'h0000_0800);
    advance();
    idle_inputs();

    // ---- randomized run against the reference model, from a fresh reset
    rst = 1'b0;
    advance();
    rst = 1'b1;
    md_rd_busy = 1'b0; md_rd_sent = 1'b0; md_rd_is_d = 1'b0; md_rd_addr = '0;
    md_last_d = 1'b0; md_wr_locked = 1'b0;
    md_wa_q.delete(); md_wd_q.delete();
    for (int c = 0; c < 600; c++) begin
      i_raddr_valid = ($urandom_range(0, 99) < 50);
      i_raddr       = $urandom;
      d_raddr_valid = ($urandom_range(0, 99) < 50);
      d_raddr       = $urandom;
      d_waddr_valid = ($urandom_range(0, 99) < 25);
      d_waddr       = $urandom;
      d_wdata_valid = ($urandom_range(0, 99) < 25);
      d_wdata       = $urandom;
      m_raddr_ready = ($urandom_range(0, 99) < 60);
      m_rdata_valid = ($urandom_range(0, 99) < 60);
      m_rdata       = $urandom;
      i_rdata_ready = ($urandom_range(0, 99) < 70);
      d_rdata_ready = ($urandom_range(0, 99) < 70);
      m_waddr_ready = ($urandom_range(0, 99) < 50);
      m_wdata_ready = ($urandom_range(0, 99) < 50);
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
